// File: rtl/tff_count_ctrl.sv
// Sequencer for an external bank of T flip-flops: clears the bank, then
// drives toggle inputs so it counts up or down to a latched terminal value.
module tff_count_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic [WIDTH-1:0] load_val,
   input  logic             up,
   input  logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] t,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_COUNT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] term_q,  term_d;
   logic             dir_q,   dir_d;
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;

   // Toggle pattern for one +/-1 step: bit i flips when all lower bits are 1 (up) or 0 (down).
   function automatic logic [WIDTH-1:0] step_toggles(input logic [WIDTH-1:0] cur,
                                                     input logic             dir_up);
      logic [WIDTH-1:0] v;
      logic             carry;
      v     = {WIDTH{1'b0}};
      carry = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         v[i]  = carry;
         carry = carry & (dir_up ? cur[i] : ~cur[i]);
      end
      return v;
   endfunction

   // Next-state and toggle-output decode.
   always_comb begin
      state_d = state_q;
      term_d  = term_q;
      dir_d   = dir_q;
      t       = {WIDTH{1'b0}};
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               term_d  = load_val;
               dir_d   = up;
               state_d = ST_CLEAR;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            t = q;
            if (stop) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_COUNT;
            end
         end
         ST_COUNT: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (q == term_q) begin
               state_d = ST_DONE;
            end else begin
               t = step_toggles(q, dir_q);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // A reset edge must leave the bank frozen, so no cell may toggle on it.
      if (!reset) begin
         t = {WIDTH{1'b0}};
      end else begin
         t = t;
      end
      busy_d = (state_d == ST_CLEAR) || (state_d == ST_COUNT);
      done_d = (state_d == ST_DONE);
   end

   // State, latched run parameters and registered status outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         term_q  <= {WIDTH{1'b0}};
         dir_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         term_q  <= term_d;
         dir_q   <= dir_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Bench: 4-cell T flip-flop bank around tff_count_ctrl, a timeline model of
// each run checked every cycle, plus directed literal expectations.
module tb_tff_count_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0, start = 1'b0, stop = 1'b0, up = 1'b0;
   logic [3:0] load_val = 4'd0;
   logic [3:0] t_s;
   logic       busy_s, done_s;
   logic [3:0] bank = 4'd0;
   logic       pre_en = 1'b1;
   logic [3:0] pre_val = 4'd0;

   int cyc = 0, n_cmp = 0, n_err = 0, done_cnt = 0;
   bit chk_en = 1'b0;

   // Model: position inside the current run plus the arithmetic bank value.
   bit         act = 1'b0;
   int         pos = 0, n_steps = 0;
   bit         dir_up = 1'b1;
   logic [3:0] m_bank = 4'd0;
   logic       exp_busy, exp_done, in_clear, in_count;
   logic [3:0] nxt, exp_t;

   tff_count_ctrl #(.WIDTH(4)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .load_val(load_val),
      .up(up), .q(bank), .t(t_s), .busy(busy_s), .done(done_s)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // The T flip-flop cells, with a preload port for the bench.
   always @(posedge clk) begin
      if (pre_en) bank <= pre_val;
      else        bank <= bank ^ t_s;
   end

   always_comb begin
      in_clear = act && (pos == 1);
      in_count = act && (pos >= 2) && (pos <= 2 + n_steps);
      exp_busy = in_clear || in_count;
      exp_done = act && (pos == 3 + n_steps);
      nxt      = m_bank;
      if (reset) begin
         if (in_clear) nxt = 4'd0;
         else if (in_count && !stop && pos < 2 + n_steps)
            nxt = dir_up ? m_bank + 4'd1 : m_bank - 4'd1;
      end
      exp_t = m_bank ^ nxt;
   end

   always @(posedge clk) begin
      if (!reset) act <= 1'b0;
      else if (act) begin
         if ((stop && pos <= 2 + n_steps) || pos == 3 + n_steps) act <= 1'b0;
         else pos <= pos + 1;
      end else if (start) begin
         act     <= 1'b1;
         pos     <= 1;
         dir_up  <= up;
         n_steps <= up ? int'(load_val) : (16 - int'(load_val)) % 16;
      end
      m_bank <= pre_en ? pre_val : nxt;
   end

   task automatic chk(string nm, int a, int e);
      n_cmp++;
      if (a != e) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, a, e, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (done_s) done_cnt++;
      if (chk_en) begin
         chk("busy", int'(busy_s), int'(exp_busy));
         chk("done", int'(done_s), int'(exp_done));
         chk("t", int'(t_s), int'(exp_t));
         chk("bank", int'(bank), int'(m_bank));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic run(input logic [3:0] lv, input bit u, output int n);
      pre_en = 1'b1; pre_val = 4'b1011;
      step();
      pre_en = 1'b0;
      load_val = lv; up = u; start = 1'b1;
      n = cyc;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input int n, input int exp_delta, input string nm);
      for (int k = 0; k < 40 && !done_s; k++) step();
      if (!done_s) chk(nm, -1, exp_delta);
      else         chk(nm, cyc - n, exp_delta);
   endtask

   initial begin
      int n, d0, first_d, last_d, cnt;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_busy", int'(busy_s), 0);
      chk("rst_done", int'(done_s), 0);
      chk("rst_t", int'(t_s), 0);
      reset = 1'b1;
      pre_en = 1'b0;
      chk_en = 1'b1;
      step();

      // Up count to 5
      run(4'd5, 1'b1, n);
      chk("up_clear_t", int'(t_s), 11);
      wait_done(n, 8, "up_done_cycle");
      step();
      chk("up_bank", int'(bank), 5);
      chk("up_busy", int'(busy_s), 0);
      chk("up_done_low", int'(done_s), 0);

      // Down count with wrap to 13
      run(4'd13, 1'b0, n);
      wait_done(n, 6, "down_done_cycle");
      repeat (3) step();
      chk("down_bank", int'(bank), 13);

      // Zero terminal, both directions
      run(4'd0, 1'b1, n);
      wait_done(n, 3, "zero_up_done_cycle");
      chk("zero_done_t", int'(t_s), 0);
      chk("zero_bank", int'(bank), 0);
      step();
      run(4'd0, 1'b0, n);
      wait_done(n, 3, "zero_dn_done_cycle");
      step();

      // Abort at q=3 during an up-to-12 run
      d0 = done_cnt;
      run(4'd12, 1'b1, n);
      for (int k = 0; k < 30 && bank != 4'd3; k++) step();
      chk("abort_reach", int'(bank), 3);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("abort_busy", int'(busy_s), 0);
      repeat (8) step();
      chk("abort_bank", int'(bank), 3);
      chk("abort_no_done", done_cnt, d0);

      // Reset mid-run at q=6 during an up-to-9 run
      run(4'd9, 1'b1, n);
      for (int k = 0; k < 30 && bank != 4'd6; k++) step();
      chk("rstrun_reach", int'(bank), 6);
      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("rstrun_busy", int'(busy_s), 0);
      chk("rstrun_done", int'(done_s), 0);
      chk("rstrun_t", int'(t_s), 0);
      chk("rstrun_bank", int'(bank), 6);
      step();
      chk("rstrun_hold", int'(bank), 6);
      run(4'd2, 1'b1, n);
      wait_done(n, 5, "rstrun_fresh_done");
      step();

      // Back-to-back runs with start held high
      pre_en = 1'b1; pre_val = 4'b1011;
      step();
      pre_en = 1'b0;
      load_val = 4'd1; up = 1'b1; start = 1'b1;
      n = cyc; first_d = -1; last_d = -1; cnt = 0;
      repeat (20) begin
         step();
         if (done_s) begin
            cnt++;
            if (first_d < 0) first_d = cyc;
            last_d = cyc;
         end
      end
      start = 1'b0;
      chk("b2b_count", cnt, 4);
      chk("b2b_first", first_d - n, 4);
      chk("b2b_span", last_d - first_d, 15);
      repeat (6) step();
      chk("b2b_bank", int'(bank), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/tff_count_ctrl.md
# tff_count_ctrl

Sequencing controller for a bank of `WIDTH` T flip-flop cells.
- Drives each cell's toggle input and reads back its Q, so the bank runs as a programmable up/down counter.
- A start command clears the bank, then counts it to a loaded terminal value.
- Signals completion with a one-cycle `done` pulse.
- The bank cells are external; this block only generates their `T` inputs.

## Interface
Parameters:
- `WIDTH`, default 4: number of T flip-flop cells in the controlled bank (≥2).

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`  in  1: level, sampled in IDLE only; begins a run.
- `stop`  in  1: abort request, sampled in CLEAR/COUNT.
- `load_val`  in  WIDTH: terminal count, latched when `start` is accepted.
- `up`  in  1: direction, latched with `load_val` (1 = up, 0 = down).
- `q`  in  WIDTH: Q outputs of the T flip-flop bank, bit i from cell i.
- `t`  out  WIDTH: toggle inputs to the bank, bit i to cell i; combinational from state and `q`.
- `busy`  out  1: high in CLEAR and COUNT.
- `done`  out  1: high for exactly one cycle in DONE.

## Operation
- Registers:
  - `state` (IDLE, CLEAR, COUNT, DONE)
  - `term[WIDTH]`
  - `dir`
- Reset (`reset`=0 at an edge):
  - state=IDLE, term=0, dir=1.
  - Outputs: `t`=0, `busy`=0, `done`=0.
  - The bank contents are not touched by reset.
- IDLE:
  - `t`=0.
  - `start`=1 → latch term=`load_val`, dir=`up`; go to CLEAR.
- CLEAR:
  - `t`=`q`, so every set cell toggles to 0 in one edge.
  - `stop`=1 → IDLE, with `t` still driven `q` this cycle.
  - Otherwise go to COUNT.
- COUNT:
  - If `q`==term: `t`=0; go to DONE.
  - Else, up: t[0]=1, t[i]=&q[i-1:0].
  - Else, down: t[0]=1, t[i]=&~q[i-1:0].
  - Arithmetic is modulo 2^WIDTH; down from 0 wraps to all-ones.
  - `stop`=1 has priority over the compare: `t`=0 this cycle, go to IDLE, bank holds its current value.
- DONE:
  - `t`=0, `done`=1; next state IDLE unconditionally.
  - `start` is ignored in DONE.
  - `start` still high in the following IDLE cycle triggers a new run.
- Steps per run:
  - Up: N = term.
  - Down: N = (2^WIDTH − term) mod 2^WIDTH.
- Bank value after `done`:
  - Equals term and holds until the next run.
  - `t`=0 outside CLEAR/COUNT.

## Timing
- `start` sampled high at edge n:
  - CLEAR during cycle n+1.
  - First COUNT cycle n+2 with `q`=0.
  - `done` high during cycle n+3+N.
  - `busy` high cycles n+1 … n+2+N.
- term=0 with up=1, or term=0 with up=0: N=0, `done` at n+3.
- `reset` low mid-run: IDLE next cycle, `t`=0, `busy`/`done` low; bank freezes at its current value.
- `reset` low has priority over `start` and `stop` in the same cycle.
- `q` is assumed to settle within one cycle of the toggle edge: standard T_ff cells on the same `clk`.
- `load_val`/`up` changes after acceptance have no effect until the next accepted `start`.

## Test plan
Bench: `WIDTH`=4, 4 T_ff cells on `clk`, Q fed back to `q`, cells pre-loaded to 1011 before each run.
- Up count: `start`=1 with `load_val`=5, `up`=1 at edge n → CLEAR zeroes bank at n+1; `q` steps 0,1,2,3,4,5; `done`=1 only in cycle n+8; `q`=0101 afterwards; `busy`=0.
- Down wrap: `load_val`=13, `up`=0 → `q` 0,15,14,13; `done` at n+6; `q` holds 1101.
- Zero terminal: `load_val`=0, `up`=1 → bank cleared, `done` at n+3, `t`=0 in DONE.
- Abort: `load_val`=12, `up`=1; `stop`=1 in the cycle where `q`=3 → IDLE next cycle, `q` stays 0011, `done` never asserts, `busy`=0.
- Reset mid-run: `reset`=0 for one edge while `q`=6 during an up-to-9 run → `busy`=0, `done`=0, `t`=0 next cycle; bank holds 0110; a fresh `start` with `load_val`=2 gives `done` at n+5.
- Back-to-back: `start` held high continuously, `load_val`=1 → `done` pulses every 5 cycles, never two consecutive cycles high.
